// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: walks one external 4x4 sub-multiplier
// over the LL/LH/HL/HH quadrants and accumulates the shifted partial products.
module mult_8x8_seq_ctrl #(
  parameter logic [3:0] QUAD_MODE = 4'b1100,
  parameter bit         SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic        sub_mode,
  input  logic [7:0]  sub_r,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_LL, S_LH, S_HL, S_HH, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_a, r_b;
  logic [15:0] r_acc;
  logic        r_in_ready, r_out_valid, r_busy, r_sub_mode;
  logic [15:0] r_out_r;
  logic [3:0]  r_sub_a, r_sub_b;

  logic [15:0] w_ext, w_add, w_sum;
  logic        w_zero;

  assign w_ext  = {8'h00, sub_r};
  assign w_sum  = r_acc + w_add;
  assign w_zero = SKIP_ZERO && ((in_a == 8'h00) || (in_b == 8'h00));

  // Quadrant weight: LL x1, cross terms x16, HH x256.
  always_comb begin
    w_add = 16'h0000;
    case (r_state)
      S_LL:       w_add = w_ext;
      S_LH, S_HL: w_add = w_ext << 4;
      S_HH:       w_add = w_ext << 8;
      default:    w_add = 16'h0000;
    endcase
  end

  // Outputs are registered, so each transition loads the values the next state shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_acc       <= 16'h0000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_r     <= 16'h0000;
      r_busy      <= 1'b0;
      r_sub_a     <= 4'h0;
      r_sub_b     <= 4'h0;
      r_sub_mode  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_acc      <= 16'h0000;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_zero) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_r     <= 16'h0000;
            end else begin
              r_state    <= S_LL;
              r_sub_a    <= in_a[3:0];
              r_sub_b    <= in_b[3:0];
              r_sub_mode <= QUAD_MODE[0];
            end
          end
        end
        S_LL: begin
          r_acc      <= w_sum;
          r_state    <= S_LH;
          r_sub_a    <= r_a[3:0];
          r_sub_b    <= r_b[7:4];
          r_sub_mode <= QUAD_MODE[1];
        end
        S_LH: begin
          r_acc      <= w_sum;
          r_state    <= S_HL;
          r_sub_a    <= r_a[7:4];
          r_sub_b    <= r_b[3:0];
          r_sub_mode <= QUAD_MODE[2];
        end
        S_HL: begin
          r_acc      <= w_sum;
          r_state    <= S_HH;
          r_sub_a    <= r_a[7:4];
          r_sub_b    <= r_b[7:4];
          r_sub_mode <= QUAD_MODE[3];
        end
        S_HH: begin
          r_acc       <= w_sum;
          r_out_r     <= w_sum;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
          r_sub_a     <= 4'h0;
          r_sub_b     <= 4'h0;
          r_sub_mode  <= 1'b0;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_r     <= 16'h0000;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_r     <= 16'h0000;
          r_busy      <= 1'b0;
          r_sub_a     <= 4'h0;
          r_sub_b     <= 4'h0;
          r_sub_mode  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign busy      = r_busy;
  assign sub_a     = r_sub_a;
  assign sub_b     = r_sub_b;
  assign sub_mode  = r_sub_mode;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: exact (or stubbed) 4x4 sub-multiplier, vector
// table, handshake corner sequences and random operands against a*b.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, sub_mode, busy;
  logic [7:0]  in_a, in_b, sub_r;
  logic [15:0] out_r;
  logic [3:0]  sub_a, sub_b;
  logic        stub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb sub_r = stub ? 8'h01 : ({4'h0, sub_a} * {4'h0, sub_b});

  mult_8x8_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .sub_a(sub_a), .sub_b(sub_b), .sub_mode(sub_mode),
    .sub_r(sub_r), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; flags report protocol violations seen along the way.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int hold,
                    output logic [15:0] r, output int lat, output logic [3:0] modes,
                    output logic ir_bad, output logic sub_nz, output logic stable_bad,
                    output logic post_bad);
    modes = 4'h0; ir_bad = 1'b0; sub_nz = 1'b0; stable_bad = 1'b0; post_bad = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
    lat = 1;
    while (1) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ir_bad = 1'b1;
      if (out_valid === 1'b1) break;
      if (sub_a != 4'h0 || sub_b != 4'h0) sub_nz = 1'b1;
      if (lat <= 4) modes[lat-1] = sub_mode;
      if (lat >= 20) break;
      @(negedge clk);
      lat++;
    end
    r = out_r;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = 8'(h + 1); in_b = 8'h09;
      @(negedge clk);
      if (out_r !== r || out_valid !== 1'b1 || in_ready !== 1'b0) stable_bad = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_r !== 16'h0) post_bad = 1'b1;
    @(negedge clk);
    if (out_valid !== 1'b0 || busy !== 1'b0) post_bad = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic        stub;
    int          hold;
    logic [15:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] r, er;
    int          lat, elat;
    logic [3:0]  modes;
    logic        ir_bad, sub_nz, stable_bad, post_bad;
    logic [7:0]  ra, rb;

    vecs[0] = '{8'hB7, 8'h5C, 1'b0, 0, 16'h41C4, 5};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, 5};
    vecs[2] = '{8'h11, 8'h11, 1'b1, 0, 16'h0121, 5};
    vecs[3] = '{8'h00, 8'h7F, 1'b0, 0, 16'h0000, 1};
    vecs[4] = '{8'h03, 8'h05, 1'b0, 3, 16'h000F, 5};
    vecs[5] = '{8'h7F, 8'h00, 1'b0, 1, 16'h0000, 1};
    vecs[6] = '{8'h01, 8'h01, 1'b0, 2, 16'h0001, 5};

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; out_ready = 1'b0; stub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {15'h0, in_ready, out_valid, busy, out_r, sub_a, sub_b, sub_mode},
        {15'h0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0});

    for (int i = 0; i < 7; i++) begin
      stub = vecs[i].stub;
      op(vecs[i].a, vecs[i].b, vecs[i].hold, r, lat, modes, ir_bad, sub_nz, stable_bad, post_bad);
      chk($sformatf("vec%0d_result", i), {16'h0, r}, {16'h0, vecs[i].exp_r});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_in_ready_busy", i), {31'h0, ir_bad}, 32'h0);
      chk($sformatf("vec%0d_post_release", i), {31'h0, post_bad}, 32'h0);
      if (vecs[i].hold > 0) chk($sformatf("vec%0d_hold_stable", i), {31'h0, stable_bad}, 32'h0);
      if (vecs[i].exp_lat == 5) chk($sformatf("vec%0d_sub_mode_seq", i), {28'h0, modes}, {28'h0, 4'b1100});
      else chk($sformatf("vec%0d_skip_no_quadrant", i), {31'h0, sub_nz}, 32'h0);
    end
    stub = 1'b0;

    // Reset arriving while the LH quadrant is active.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h9D;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lh_before_reset_sub_b", {28'h0, sub_b}, {28'h0, 4'h9});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_op_reset", {13'h0, in_ready, busy, out_valid, out_r},
        {13'h0, 1'b1, 1'b0, 1'b0, 16'h0});
    repeat (6) @(negedge clk);
    chk("reset_discards_result", {31'h0, out_valid}, 32'h0);
    op(8'h02, 8'h03, 0, r, lat, modes, ir_bad, sub_nz, stable_bad, post_bad);
    chk("after_reset_result", {16'h0, r}, 32'h0006);
    chk("after_reset_latency", lat, 5);

    // Random operands against plain multiplication.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(7) == 0) ra = 8'h00;
      if ($urandom_range(7) == 0) rb = 8'h00;
      er   = 16'(ra) * 16'(rb);
      elat = (ra == 8'h00 || rb == 8'h00) ? 1 : 5;
      op(ra, rb, int'($urandom_range(2)), r, lat, modes, ir_bad, sub_nz, stable_bad, post_bad);
      chk($sformatf("rnd%0d_%h_%h_result", n, ra, rb), {16'h0, r}, {16'h0, er});
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_protocol", n), {29'h0, ir_bad, stable_bad, post_bad}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
